mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares one single-ported synchronous RAM between the pipeline's instruction-fetch port and its data (load/store) port. The block sits between the core and the unified memory. Each cycle it grants at most one requester. Data has priority by default, but a bounded-streak rule prevents fetch starvation. The block returns read data one cycle after the grant, and its grant outputs drive the core's stall logic.

Parameters:
ADDR_W, 32, byte-address width on all ports
DATA_W, 32, data width; DATA_W/8 mask bits
MAX_DATA_STREAK, 4, maximum consecutive data grants while fetch waits; 0 disables the rule (strict data priority)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
i_req  in  1  fetch request; held until granted
i_addr  in  ADDR_W  fetch byte address
i_gnt  out  1  fetch granted this cycle (combinational)
i_rvalid  out  1  fetch data valid (cycle after grant)
i_rdata  out  DATA_W  fetch read data; holds last value
d_req  in  1  data request; held until granted
d_we  in  1  1 = store, 0 = load
d_wmask  in  DATA_W/8  byte-lane write enables
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data granted this cycle (combinational)
d_rvalid  out  1  load data valid / store ack (cycle after grant)
d_rdata  out  DATA_W  load data; holds last value
mem_addr  out  ADDR_W  RAM address
mem_we  out  1  RAM write enable
mem_wmask  out  DATA_W/8  RAM byte mask
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; valid 1 cycle after address

Behaviour:
- Reset (rst=1 at a clk edge):
  - rsp_owner goes to NONE; streak goes to 0; i_rvalid and d_rvalid go to 0; i_rdata and d_rdata go to 0.
  - While rst=1: i_gnt, d_gnt and mem_we are forced to 0.
  - A response pending at reset is discarded and never reported.
- Arbitration is combinational within a cycle:
  - d_req only: d_gnt=1.
  - i_req only: i_gnt=1.
  - Both asserted: d_gnt=1, unless MAX_DATA_STREAK>0 and streak==MAX_DATA_STREAK, in which case i_gnt=1.
  - Neither asserted: no grant; mem_we=0; mem_addr=0.
- Memory command in the grant cycle:
  - Data grant: mem_addr=d_addr, mem_we=d_we, mem_wmask=d_we ? d_wmask : 0, mem_wdata=d_wdata.
  - Fetch grant: mem_addr=i_addr, mem_we=0, mem_wmask=0.
  - Masks and addresses pass through unmodified; alignment is the requester's responsibility.
- Response state machine (rsp_owner register; states NONE, I, D):
  - Next state equals the grant made this cycle: I, D, or NONE.
  - In state I: i_rvalid=1 and i_rdata is loaded from mem_rdata.
  - In state D: d_rvalid=1, and d_rdata is loaded from mem_rdata only if the granted access was a load (store-flag register). A store acks with d_rvalid and leaves d_rdata unchanged.
  - rdata registers hold their value between responses.
  - i_rvalid and d_rvalid are never both 1.
- Throughput and latency:
  - Back-to-back grants are allowed; a requester may present a new request in the same cycle its rvalid is high.
  - Sustained throughput is one access per cycle.
  - Latency from grant to rvalid is exactly 1 cycle.
- Streak counter, width $clog2(MAX_DATA_STREAK+1):
  - Increments on a data grant while i_req=1.
  - Clears on any fetch grant, or whenever i_req=0.
  - Saturates at MAX_DATA_STREAK.
- Handshake rules:
  - A requester keeps req and its payload stable until it sees gnt.
  - Dropping req before gnt is legal; the request is simply not serviced.
  - Holding req after gnt is treated as a new request.
- Write-then-read to the same address in consecutive cycles returns the new data. This relies on RAM write-first or separate-cycle ordering; the arbiter adds no bypass.

Decomposition:
- Shared package (mem_arb_pkg): typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e; localparam default widths.
- One sub-module, mem_arb_fairness: holds the streak counter and produces the force_fetch flag.
- All other logic stays flat in mem_port_arbiter.

Test Plan:
1. Reset: hold rst for 3 cycles with i_req=d_req=1 -> gnt=0, mem_we=0, rvalids=0, rdata=0 throughout; after release, the first grant goes to d.
2. Fetch only: i_req=1, i_addr=0x100, RAM holds 0x00000013 -> i_gnt=1 in the same cycle, mem_addr=0x100; next cycle i_rvalid=1, i_rdata=0x00000013.
3. Store then load: d store addr=0x200, wdata=0xDEADBEEF, mask=4'b1111, then load from 0x200 -> cycle 0: mem_we=1, mem_wmask=4'hF; cycle 1: d_rvalid=1, d_rdata unchanged; cycle 2: d_rvalid=1, d_rdata=0xDEADBEEF.
4. Contention with MAX_DATA_STREAK=4: i_req and d_req held high for 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I.
5. Strict priority with MAX_DATA_STREAK=0 and the same stimulus -> 10 data grants, i_gnt stays 0.
6. Reset mid-response: assert rst in the cycle after a fetch grant -> i_rvalid stays 0, i_rdata=0, and no late response appears after release.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Which requester owns the response slot in the current cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_DATA_W          = 32;
    localparam int DEF_MAX_DATA_STREAK = 4;

    // Streak counter width; never narrower than one bit so a disabled rule
    // still yields a legal vector.
    function automatic int streak_w(input int max_streak);
        return (max_streak > 0) ? $clog2(max_streak + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// Counts consecutive data grants made while fetch is waiting and raises
// force_fetch once the limit is reached, so fetch cannot starve.
module mem_arb_fairness
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic clk,
    input  logic rst,
    input  logic i_fetch_req,
    input  logic i_fetch_gnt,
    input  logic i_data_gnt,
    output logic o_force_fetch
);

    localparam int SW = streak_w(MAX_DATA_STREAK);
    localparam logic [SW-1:0] MAX_V = SW'(MAX_DATA_STREAK);

    logic [SW-1:0] r_streak;

    // Streak: cleared when fetch is served or idle, saturating count of data wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_streak <= '0;
        end else if (i_fetch_gnt || !i_fetch_req) begin
            r_streak <= '0;
        end else if (i_data_gnt && (r_streak != MAX_V)) begin
            r_streak <= r_streak + 1'b1;
        end
    end

    // A limit of zero disables the rule entirely (strict data priority).
    assign o_force_fetch = (MAX_DATA_STREAK > 0) && i_fetch_req && (r_streak == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous RAM between the fetch port and the
// load/store port. At most one grant per cycle, data wins unless fetch has
// waited through MAX_DATA_STREAK data grants. Read data returns one cycle
// after the grant.
//
// Handshake: a requester holds req and payload stable until it sees gnt in
// the same cycle; gnt is combinational. The matching rvalid is high exactly
// one cycle later; req held high after gnt is a fresh request.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W,
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_wmask,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_wmask,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output owner_e              o_dbg_owner
);

    logic        w_force_fetch;
    logic        w_i_gnt;
    logic        w_d_gnt;
    owner_e      w_owner_nxt;
    logic        w_i_rvalid;
    logic        w_d_rvalid;

    owner_e      r_owner;
    logic        r_store;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    mem_arb_fairness #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_fairness (
        .clk           (clk),
        .rst           (rst),
        .i_fetch_req   (i_req),
        .i_fetch_gnt   (w_i_gnt),
        .i_data_gnt    (w_d_gnt),
        .o_force_fetch (w_force_fetch)
    );

    // Grant selection: data first unless the fairness rule forces a fetch.
    always_comb begin
        w_d_gnt = 1'b0;
        w_i_gnt = 1'b0;
        if (!rst) begin
            if (d_req && !w_force_fetch) begin
                w_d_gnt = 1'b1;
            end else if (i_req) begin
                w_i_gnt = 1'b1;
            end
        end
    end

    // RAM command mux; idle cycles drive a quiet all-zero command.
    always_comb begin
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wmask   = '0;
        mem_wdata   = '0;
        w_owner_nxt = OWN_NONE;
        if (w_d_gnt) begin
            mem_addr    = d_addr;
            mem_we      = d_we;
            mem_wmask   = d_we ? d_wmask : '0;
            mem_wdata   = d_wdata;
            w_owner_nxt = OWN_D;
        end else if (w_i_gnt) begin
            mem_addr    = i_addr;
            w_owner_nxt = OWN_I;
        end
    end

    // Response FSM: owner follows the grant; rdata registers capture the RAM
    // word during the response cycle and hold it until the next response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner   <= OWN_NONE;
            r_store   <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_store <= w_d_gnt && d_we;
            if (r_owner == OWN_I) begin
                r_i_rdata <= mem_rdata;
            end
            if ((r_owner == OWN_D) && !r_store) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    // A response in flight when reset arrives is suppressed, not reported.
    assign w_i_rvalid = !rst && (r_owner == OWN_I);
    assign w_d_rvalid = !rst && (r_owner == OWN_D);

    assign i_gnt       = w_i_gnt;
    assign d_gnt       = w_d_gnt;
    assign i_rvalid    = w_i_rvalid;
    assign d_rvalid    = w_d_rvalid;
    assign i_rdata     = w_i_rvalid ? mem_rdata : r_i_rdata;
    assign d_rdata     = (w_d_rvalid && !r_store) ? mem_rdata : r_d_rdata;
    assign o_dbg_owner = r_owner;

endmodule
